archel_exec_ctrl: RTL

Run/pause/single-step sequencer for the archel core. Conditions the raw PAUSE and STEP buttons (synchronise, debounce, edge-detect). Runs a three-state execution FSM. Drives the core's clock-enable, so the core advances continuously at a divided rate, one instruction per STEP press, or not at all. Sits between the board buttons and the core, and gives the VGA status overlay its state and cycle-count outputs.

---
 rtl/archel_pkg.sv | 14 +
 rtl/archel_debounce.sv | 49 ++++
 rtl/archel_exec_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/archel_pkg.sv
// archel_pkg: shared types and constants for the archel execution controller.
//   exec_state_t : execution FSM state encoding
//   CYC_W        : width of the retired-cycle counter seen by the status overlay
package archel_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STEP    = 2'd2
  } exec_state_t;

  localparam int CYC_W = 16;

endpackage

// File: rtl/archel_debounce.sv
// archel_debounce: conditions one raw push-button.
//   CLK, RST : system clock, async active-low reset
//   btn      : raw asynchronous button level (active-high)
//   evt      : one-cycle pulse on each accepted rising edge of the button
// Path: 2-flop synchroniser -> stability counter -> registered rising-edge detect.
module archel_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic evt
);

  // Counter only ever holds 0..DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      evt     <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      // The final mismatching sample is the DEBOUNCE_CYCLES-th one, so the
      // level flips on the same edge the counter would reach the limit.
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      evt     <= level & ~level_d;
    end
  end

endmodule

// File: rtl/archel_exec_ctrl.sv
// archel_exec_ctrl: run/pause/single-step sequencer for the archel core.
//   CLK, RST : system clock, async active-low reset
//   PAUSE    : raw pause/resume button (toggles PAUSED <-> RUNNING)
//   STEP     : raw single-step button (one core cycle from PAUSED)
//   HALT     : core halted level; forces/holds PAUSED and masks the enable
//   CPU_EN   : core clock-enable
//   RUNNING  : FSM is in the RUNNING state
//   CYC_CNT  : number of enabled core cycles since reset (wraps)
module archel_exec_ctrl
  import archel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 4,
  parameter bit RESET_RUN       = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PAUSE,
  input  logic             STEP,
  input  logic             HALT,
  output logic             CPU_EN,
  output logic             RUNNING,
  output logic [CYC_W-1:0] CYC_CNT
);

  localparam int NUM_BTN = 2;
  localparam int DW      = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam exec_state_t RST_STATE = RESET_RUN ? ST_RUNNING : ST_PAUSED;

  // Button lanes: [0] = PAUSE, [1] = STEP.
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_evt;
  logic               pause_evt;
  logic               step_evt;

  assign btn_raw   = {STEP, PAUSE};
  assign pause_evt = btn_evt[0];
  assign step_evt  = btn_evt[1];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    archel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK (CLK),
      .RST (RST),
      .btn (btn_raw[g]),
      .evt (btn_evt[g])
    );
  end

  exec_state_t      state, state_nxt;
  logic [DW-1:0]    div;
  logic             tick;
  logic [CYC_W-1:0] cyc_q;

  assign tick    = (div == DW'(RUN_DIV - 1));
  assign RUNNING = (state == ST_RUNNING);
  assign CYC_CNT = cyc_q;
  // Gated by RST so nothing escapes while reset is held, even with RUN_DIV=1.
  assign CPU_EN  = RST & ((state == ST_STEP) |
                          ((state == ST_RUNNING) & tick & ~HALT));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PAUSED: begin
        // Halt blocks both exits; pause has priority over step.
        if (!HALT) begin
          if (pause_evt)     state_nxt = ST_RUNNING;
          else if (step_evt) state_nxt = ST_STEP;
        end
      end
      ST_RUNNING: if (pause_evt || HALT) state_nxt = ST_PAUSED;
      ST_STEP:    state_nxt = ST_PAUSED;
      default:    state_nxt = ST_PAUSED;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= RST_STATE;
      div   <= '0;
      cyc_q <= '0;
    end else begin
      state <= state_nxt;
      // Restart the divider on each entry so the first enable lands
      // RUN_DIV cycles after the event, independent of history.
      if (state_nxt == ST_RUNNING && state != ST_RUNNING) div <= '0;
      else if (state == ST_RUNNING)                       div <= tick ? '0 : div + 1'b1;
      if (CPU_EN) cyc_q <= cyc_q + 1'b1;
    end
  end

endmodule
